// File: rtl/vertex_transform_dim_4_pkg.sv
// Shared types, widths and the saturating narrow for the vertex transform block.
package vertex_transform_dim_4_pkg;

    localparam int unsigned DATAWIDTH = 18;
    localparam int unsigned FRAC_BITS = 12;
    localparam int unsigned PRODW     = 2 * DATAWIDTH;
    localparam int unsigned SUMW      = 2 * DATAWIDTH + 2;

    typedef logic signed [DATAWIDTH-1:0] elem_t;
    typedef logic signed [PRODW-1:0]     prod_t;
    typedef logic signed [SUMW-1:0]      acc_t;

    // Index 0 is x (or column 0); a matrix is indexed [row][col].
    typedef elem_t [3:0] vec4_t;
    typedef vec4_t [3:0] mat4_t;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReady   = 2'd1,
        StCompute = 2'd2,
        StOutput  = 2'd3
    } state_e;

    localparam acc_t ELEM_MAX = acc_t'((2 ** (DATAWIDTH - 1)) - 1);
    localparam acc_t ELEM_MIN = -ELEM_MAX - acc_t'(1);

    // Clamp a wide accumulator value into the element range.
    function automatic elem_t saturate(input acc_t x);
        if (x > ELEM_MAX) begin
            return elem_t'(ELEM_MAX);
        end else if (x < ELEM_MIN) begin
            return elem_t'(ELEM_MIN);
        end else begin
            return elem_t'(x);
        end
    endfunction

endpackage

// File: rtl/vertex_transform_dim_4_dot_product_4.sv
// Combinational 4-term signed dot product, rescaled by FRAC_BITS and saturated.
module dot_product_4
    import vertex_transform_dim_4_pkg::*;
(
    input  vec4_t a,
    input  vec4_t b,
    output elem_t result
);

    prod_t prod [4];
    acc_t  sum;
    acc_t  shifted;

    // Full-width products, sign-extended sum, floor shift, then clamp.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            prod[i] = prod_t'(a[i]) * prod_t'(b[i]);
        end
        sum = acc_t'(prod[0]) + acc_t'(prod[1]) + acc_t'(prod[2]) + acc_t'(prod[3]);
        // Arithmetic shift truncates toward minus infinity.
        shifted = sum >>> FRAC_BITS;
        result  = saturate(shifted);
    end

endmodule

// File: rtl/vertex_transform_dim_4.sv
// Applies a latched 4x4 fixed-point matrix to a stream of homogeneous vertices,
// one matrix row per cycle through a single shared dot-product unit.
module vertex_transform_dim_4
    import vertex_transform_dim_4_pkg::*;
(
    input  logic  clk,
    input  logic  rstn,
    input  mat4_t M,
    input  logic  i_m_dv,
    output logic  o_m_ready,
    input  vec4_t i_v,
    input  logic  i_v_dv,
    output logic  o_v_ready,
    output vec4_t o_p,
    output logic  o_p_dv,
    input  logic  i_p_ready
);

    state_e     state_q, state_d;
    mat4_t      mat_q, mat_d;
    vec4_t      vtx_q, vtx_d;
    vec4_t      p_q, p_d;
    logic [1:0] row_q, row_d;
    elem_t      row_result;

    dot_product_4 u_dot (
        .a      (mat_q[row_q]),
        .b      (vtx_q),
        .result (row_result)
    );

    // Handshake outputs decode from state only, so no input reaches them combinationally.
    always_comb begin
        o_m_ready = (state_q == StIdle) || (state_q == StReady);
        o_v_ready = (state_q == StReady);
        o_p_dv    = (state_q == StOutput);
        o_p       = p_q;
    end

    // Next-state, operand latching and per-row result write.
    always_comb begin
        state_d = state_q;
        mat_d   = mat_q;
        vtx_d   = vtx_q;
        p_d     = p_q;
        row_d   = row_q;
        unique case (state_q)
            StIdle: begin
                if (i_m_dv) begin
                    mat_d   = M;
                    state_d = StReady;
                end
            end
            StReady: begin
                if (i_m_dv) begin
                    mat_d = M;
                end
                // A simultaneous matrix load is used by this vertex since rows
                // read mat_q only from the next cycle on.
                if (i_v_dv) begin
                    vtx_d   = i_v;
                    row_d   = 2'd0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                p_d[row_q] = row_result;
                row_d      = row_q + 2'd1;
                if (row_q == 2'd3) begin
                    state_d = StOutput;
                end
            end
            StOutput: begin
                if (i_p_ready) begin
                    state_d = StReady;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            mat_q   <= '0;
            vtx_q   <= '0;
            p_q     <= '0;
            row_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
            vtx_q   <= vtx_d;
            p_q     <= p_d;
            row_q   <= row_d;
        end
    end

endmodule

// File: tb/tb_vertex_transform_dim_4.sv
// Directed self-checking bench for vertex_transform_dim_4.
module tb_vertex_transform_dim_4;
    import vertex_transform_dim_4_pkg::*;

    localparam int ONE = 4096;

    logic  clk;
    logic  rstn;
    mat4_t M;
    logic  i_m_dv;
    logic  o_m_ready;
    vec4_t i_v;
    logic  i_v_dv;
    logic  o_v_ready;
    vec4_t o_p;
    logic  o_p_dv;
    logic  i_p_ready;

    int n_cmp;
    int n_err;
    vec4_t held;

    vertex_transform_dim_4 dut (
        .clk       (clk),
        .rstn      (rstn),
        .M         (M),
        .i_m_dv    (i_m_dv),
        .o_m_ready (o_m_ready),
        .i_v       (i_v),
        .i_v_dv    (i_v_dv),
        .o_v_ready (o_v_ready),
        .o_p       (o_p),
        .o_p_dv    (o_p_dv),
        .i_p_ready (i_p_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic m_rdy, input logic v_rdy,
                               input logic p_dv);
        check({tag, ".o_m_ready"}, 32'(o_m_ready), 32'(m_rdy));
        check({tag, ".o_v_ready"}, 32'(o_v_ready), 32'(v_rdy));
        check({tag, ".o_p_dv"}, 32'(o_p_dv), 32'(p_dv));
    endtask

    task automatic check_vec(input string tag, input int e0, input int e1, input int e2,
                             input int e3);
        check({tag, ".p0"}, 32'($signed(o_p[0])), e0);
        check({tag, ".p1"}, 32'($signed(o_p[1])), e1);
        check({tag, ".p2"}, 32'($signed(o_p[2])), e2);
        check({tag, ".p3"}, 32'($signed(o_p[3])), e3);
    endtask

    task automatic set_identity();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                M[r][c] = (r == c) ? elem_t'(ONE) : elem_t'(0);
            end
        end
    endtask

    task automatic set_all(input int val);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                M[r][c] = elem_t'(val);
            end
        end
    endtask

    task automatic set_vtx(input int x, input int y, input int z, input int w);
        i_v[0] = elem_t'(x);
        i_v[1] = elem_t'(y);
        i_v[2] = elem_t'(z);
        i_v[3] = elem_t'(w);
    endtask

    // Three row cycles that must not yet show a valid result, then the fourth.
    task automatic run_rows(input string tag);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check({tag, ".early_dv"}, 32'(o_p_dv), 0);
        end
        tick();
        check({tag, ".dv_at_4"}, 32'(o_p_dv), 1);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rstn      = 1'b0;
        M         = '0;
        i_m_dv    = 1'b0;
        i_v       = '0;
        i_v_dv    = 1'b0;
        i_p_ready = 1'b0;

        // Reset state.
        tick();
        tick();
        rstn = 1'b1;
        check_flags("reset", 1'b1, 1'b0, 1'b0);
        check_vec("reset", 0, 0, 0, 0);

        // Vertex offered before any matrix: must be ignored.
        set_vtx(ONE, -2 * ONE, 3 * ONE, ONE);
        i_v_dv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_flags("no_matrix", 1'b1, 1'b0, 1'b0);
        end

        // Load identity; the held vertex is accepted the following cycle.
        set_identity();
        i_m_dv = 1'b1;
        tick();
        i_m_dv = 1'b0;
        check_flags("loaded", 1'b1, 1'b1, 1'b0);
        tick();
        i_v_dv = 1'b0;
        check_flags("accepted", 1'b0, 1'b0, 1'b0);
        run_rows("identity");
        check_vec("identity", ONE, -2 * ONE, 3 * ONE, ONE);

        // Backpressure: result holds, matrix load attempt is ignored.
        held = o_p;
        set_all(0);
        i_m_dv = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_flags("stall", 1'b0, 1'b0, 1'b1);
            check("stall.o_p", 32'(o_p === held), 1);
        end
        i_m_dv    = 1'b0;
        i_p_ready = 1'b1;
        tick();
        i_p_ready = 1'b0;
        check_flags("release", 1'b1, 1'b1, 1'b0);

        // Identity must still be in force after the ignored load.
        set_vtx(100, -200, 300, ONE);
        i_v_dv = 1'b1;
        tick();
        i_v_dv = 1'b0;
        run_rows("kept_identity");
        check_vec("kept_identity", 100, -200, 300, ONE);
        i_p_ready = 1'b1;
        tick();
        check_flags("ready_again", 1'b1, 1'b1, 1'b0);

        // Translation matrix loaded in the same cycle as the vertex.
        set_identity();
        M[0][3] = elem_t'(2 * ONE);
        M[1][3] = elem_t'(-ONE);
        i_m_dv  = 1'b1;
        set_vtx(1000, 2000, 3000, ONE);
        i_v_dv  = 1'b1;
        tick();
        i_m_dv = 1'b0;
        i_v_dv = 1'b0;
        run_rows("translate");
        check_vec("translate", 9192, -2096, 3000, ONE);
        tick();
        check_flags("min_period", 1'b1, 1'b1, 1'b0);

        // Positive saturation.
        set_all(131071);
        i_m_dv = 1'b1;
        set_vtx(131071, 131071, 131071, 131071);
        i_v_dv = 1'b1;
        tick();
        i_m_dv = 1'b0;
        i_v_dv = 1'b0;
        run_rows("sat_pos");
        check_vec("sat_pos", 131071, 131071, 131071, 131071);
        tick();

        // Negative saturation with the same matrix.
        set_vtx(-131071, -131071, -131071, -131071);
        i_v_dv = 1'b1;
        tick();
        i_v_dv = 1'b0;
        run_rows("sat_neg");
        check_vec("sat_neg", -131072, -131072, -131072, -131072);
        tick();

        // Reset while row 2 is being computed.
        set_identity();
        i_m_dv = 1'b1;
        set_vtx(7, 8, 9, ONE);
        i_v_dv = 1'b1;
        tick();
        i_m_dv = 1'b0;
        i_v_dv = 1'b0;
        tick();
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_flags("mid_reset", 1'b1, 1'b0, 1'b0);
        check_vec("mid_reset", 0, 0, 0, 0);

        // Vertex ignored until a matrix is reloaded.
        i_v_dv = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_flags("post_reset", 1'b1, 1'b0, 1'b0);
        end
        i_m_dv = 1'b1;
        tick();
        i_m_dv = 1'b0;
        i_v_dv = 1'b0;
        check_flags("reloaded", 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
